// File: rtl/text_write_ctrl_if.sv
// Byte-in / character-RAM-out bus of the text write controller.
// Carries UART byte handshake, clear request, RAM write port and cursor/status.
interface text_write_ctrl_if #(
  parameter int unsigned ROW_W = 2,
  parameter int unsigned COL_W = 5
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             clr_req;
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [7:0]       wr_data;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             busy;

  modport master (
    output rx_data, rx_valid, clr_req,
    input  rx_ready, wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, busy
  );

  modport slave (
    input  rx_data, rx_valid, clr_req,
    output rx_ready, wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, busy
  );
endinterface

// File: rtl/text_write_ctrl.sv
// Turns received UART bytes into character-RAM writes with a text cursor,
// handling CR/LF/BS and a full-screen clear sweep.
module text_write_ctrl #(
  parameter int unsigned COLS  = 32,
  parameter int unsigned ROWS  = 4,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input logic              clk,
  input logic              reset,
  text_write_ctrl_if.slave bus
);
  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned IDX_W = ROW_W + COL_W;
  localparam logic [7:0]  CH_BS = 8'h08;
  localparam logic [7:0]  CH_LF = 8'h0A;
  localparam logic [7:0]  CH_CR = 8'h0D;

  typedef enum logic [1:0] {IDLE, EMIT, CLEAR} state_e;

  typedef struct packed {
    logic             we;
    logic [ROW_W-1:0] wrow;
    logic [COL_W-1:0] wcol;
    logic [7:0]       wdata;
    logic [ROW_W-1:0] nrow;
    logic [COL_W-1:0] ncol;
  } step_t;

  // Effect of one byte on the cursor: optional RAM write plus the new cursor.
  function automatic step_t decode(input logic [7:0] b, input logic [ROW_W-1:0] r,
                                   input logic [COL_W-1:0] c, input logic cr_seen);
    step_t s;
    s.we    = 1'b0;
    s.wrow  = r;
    s.wcol  = c;
    s.wdata = b;
    s.nrow  = r;
    s.ncol  = c;
    if (b >= 8'h20 && b <= 8'h7E) begin
      s.we   = 1'b1;
      s.ncol = c + COL_W'(1);
      if (c == COL_W'(COLS - 1)) s.nrow = r + ROW_W'(1);
    end else if (b == CH_CR || (b == CH_LF && !cr_seen)) begin
      s.ncol = '0;
      s.nrow = r + ROW_W'(1);
    end else if (b == CH_BS) begin
      if (c != '0) begin
        s.ncol  = c - COL_W'(1);
        s.we    = 1'b1;
        s.wcol  = c - COL_W'(1);
        s.wdata = BLANK;
      end else if (r != '0) begin
        s.nrow  = r - ROW_W'(1);
        s.ncol  = COL_W'(COLS - 1);
        s.we    = 1'b1;
        s.wrow  = r - ROW_W'(1);
        s.wcol  = COL_W'(COLS - 1);
        s.wdata = BLANK;
      end
    end
    return s;
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             pend_q, pend_d;
  logic             cr_seen_q, cr_seen_d;
  logic             rx_ready_q, rx_ready_d;
  logic             busy_q, busy_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;
  logic [ROW_W-1:0] row_q, row_d, wr_row_q, wr_row_d;
  logic [COL_W-1:0] col_q, col_d, wr_col_q, wr_col_d;
  logic             wr_en_q, wr_en_d;
  logic [7:0]       wr_data_q, wr_data_d;
  step_t            step_in_c, step_emit_c;

  // Write is decoded at accept so wr_* are visible during EMIT; the cursor
  // moves on the edge that ends EMIT, from the latched byte.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    pend_d      = pend_q;
    cr_seen_d   = cr_seen_q;
    sweep_d     = sweep_q;
    row_d       = row_q;
    col_d       = col_q;
    wr_en_d     = 1'b0;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    wr_data_d   = wr_data_q;
    step_in_c   = decode(bus.rx_data, row_q, col_q, cr_seen_q);
    step_emit_c = decode(byte_q, row_q, col_q, cr_seen_q);

    if (bus.clr_req && state_q != CLEAR) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        // A clear request in the same cycle as a valid byte wins.
        if (pend_q || bus.clr_req) begin
          state_d   = CLEAR;
          wr_en_d   = 1'b1;
          wr_row_d  = '0;
          wr_col_d  = '0;
          wr_data_d = BLANK;
          sweep_d   = IDX_W'(1);
        end else if (bus.rx_valid && rx_ready_q) begin
          state_d   = EMIT;
          byte_d    = bus.rx_data;
          wr_en_d   = step_in_c.we;
          wr_row_d  = step_in_c.wrow;
          wr_col_d  = step_in_c.wcol;
          wr_data_d = step_in_c.wdata;
        end
      end
      EMIT: begin
        state_d   = IDLE;
        row_d     = step_emit_c.nrow;
        col_d     = step_emit_c.ncol;
        cr_seen_d = (byte_q == CH_CR);
      end
      CLEAR: begin
        if (sweep_q == '0) begin
          state_d   = IDLE;
          row_d     = '0;
          col_d     = '0;
          pend_d    = 1'b0;
          cr_seen_d = 1'b0;
        end else begin
          wr_en_d              = 1'b1;
          {wr_row_d, wr_col_d} = sweep_q;
          wr_data_d            = BLANK;
          sweep_d              = sweep_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    rx_ready_d = (state_d == IDLE) && !pend_d;
    busy_d     = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_q     <= 8'h00;
      pend_q     <= 1'b0;
      cr_seen_q  <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      sweep_q    <= '0;
      row_q      <= '0;
      col_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      pend_q     <= pend_d;
      cr_seen_q  <= cr_seen_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      sweep_q    <= sweep_d;
      row_q      <= row_d;
      col_q      <= col_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.busy     = busy_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_row   = wr_row_q;
  assign bus.wr_col   = wr_col_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.cur_row  = row_q;
  assign bus.cur_col  = col_q;
endmodule

// File: tb/tb_text_write_ctrl.sv
// Bench for text_write_ctrl: a screen-level model (linear cursor index over a
// 4x32 screen) checked every cycle, plus directed literal scenarios and random traffic.
module tb_text_write_ctrl;
  localparam logic [7:0] BLANK = 8'h20;
  localparam int NCELL = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  text_write_ctrl_if #(.ROW_W(2), .COL_W(5)) bif ();

  text_write_ctrl #(.COLS(32), .ROWS(4), .BLANK(BLANK)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bif)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Screen-level effect of a byte: cursor is a linear cell index row*32+col.
  typedef struct packed {
    logic       we;
    int         waddr;
    logic [7:0] wdata;
    int         newpos;
  } eff_t;

  function automatic eff_t effect(input logic [7:0] b, input int pos, input bit cr);
    eff_t e;
    e.we = 1'b0; e.waddr = pos; e.wdata = b; e.newpos = pos;
    if (b >= 8'h20 && b <= 8'h7E) begin
      e.we = 1'b1;
      e.newpos = (pos + 1) % NCELL;
    end else if (b == 8'h0D || (b == 8'h0A && !cr)) begin
      e.newpos = ((pos / 32 + 1) % 4) * 32;
    end else if (b == 8'h08 && pos > 0) begin
      e.we = 1'b1; e.waddr = pos - 1; e.wdata = BLANK; e.newpos = pos - 1;
    end
    return e;
  endfunction

  bit         m_clearing, m_emitting, m_pend, m_cr;
  int         m_clr_idx, m_pos, m_newpos, m_waddr;
  logic [7:0] m_emit_byte, m_wdata;
  bit         m_ready, m_busy, m_wen;
  eff_t       m_eff;

  assign m_eff = effect(bif.rx_data, m_pos, m_cr);

  // Reference model: one step per clock of what the outputs must show next.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clearing <= 0; m_emitting <= 0; m_pend <= 0; m_cr <= 0;
      m_clr_idx <= 0; m_pos <= 0; m_newpos <= 0; m_waddr <= 0;
      m_emit_byte <= 8'h00; m_wdata <= 8'h00;
      m_ready <= 0; m_busy <= 0; m_wen <= 0;
    end else if (m_clearing) begin
      if (m_clr_idx < NCELL - 1) begin
        m_clr_idx <= m_clr_idx + 1; m_wen <= 1; m_waddr <= m_clr_idx + 1; m_wdata <= BLANK;
      end else begin
        m_clearing <= 0; m_busy <= 0; m_wen <= 0; m_pos <= 0;
        m_pend <= 0; m_cr <= 0; m_ready <= 1;
      end
    end else if (m_emitting) begin
      m_emitting <= 0; m_pos <= m_newpos; m_cr <= (m_emit_byte == 8'h0D); m_wen <= 0;
      m_ready <= !(m_pend || bif.clr_req);
      if (bif.clr_req) m_pend <= 1;
    end else if (m_pend || bif.clr_req) begin
      m_clearing <= 1; m_clr_idx <= 0; m_wen <= 1; m_waddr <= 0; m_wdata <= BLANK;
      m_busy <= 1; m_ready <= 0; m_pend <= 1;
    end else if (bif.rx_valid && m_ready) begin
      m_emitting <= 1; m_emit_byte <= bif.rx_data; m_newpos <= m_eff.newpos;
      m_wen <= m_eff.we; m_waddr <= m_eff.waddr; m_wdata <= m_eff.wdata; m_ready <= 0;
    end else begin
      m_wen <= 0; m_ready <= 1;
    end
  end

  logic [14:0] wlog[$];
  int busy_cnt = 0;

  // Per-cycle compare against the model, plus a log of observed writes.
  always @(negedge clk) begin
    check("rx_ready", bif.rx_ready, m_ready);
    check("busy", bif.busy, m_busy);
    check("wr_en", bif.wr_en, m_wen);
    check("cursor", {bif.cur_row, bif.cur_col}, m_pos);
    if (m_wen) begin
      check("wr_addr", {bif.wr_row, bif.wr_col}, m_waddr);
      check("wr_data", bif.wr_data, m_wdata);
    end
    if (bif.wr_en) wlog.push_back({bif.wr_row, bif.wr_col, bif.wr_data});
    if (bif.busy) busy_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Hold a byte until it is taken; returns just after the accepting edge.
  task automatic send(input logic [7:0] b);
    logic rdy;
    bit done = 0;
    bif.rx_valid = 1'b1;
    bif.rx_data  = b;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk); rdy = bif.rx_ready;
      @(posedge clk); #1;
      if (rdy && !bif.clr_req) done = 1;
    end
    bif.rx_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic send_tick(input logic [7:0] b);
    send(b); tick();
  endtask

  initial begin
    int nlog, bad;
    bit pulsed;
    logic [7:0] d;
    bif.rx_valid = 0; bif.rx_data = 8'h00; bif.clr_req = 0;

    #12;
    check("rst_wr_en", bif.wr_en, 0);
    check("rst_rx_ready", bif.rx_ready, 0);
    check("rst_busy", bif.busy, 0);
    check("rst_cursor", {bif.cur_row, bif.cur_col}, 0);
    #9 rst_n = 1'b1;
    tick();
    check("ready_after_rst", bif.rx_ready, 1);

    // 'A' then 'B' from home.
    wlog.delete();
    send(8'h41);
    check("ready_low_after_A", bif.rx_ready, 0);
    tick();
    check("ready_back_after_A", bif.rx_ready, 1);
    send(8'h42);
    check("ready_low_after_B", bif.rx_ready, 0);
    tick();
    check("ab_nwrites", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      check("ab_w0", wlog[0], {2'd0, 5'd0, 8'h41});
      check("ab_w1", wlog[1], {2'd0, 5'd1, 8'h42});
    end
    check("ab_cursor", {bif.cur_row, bif.cur_col}, {2'd0, 5'd2});

    // Fill row 3 then wrap to row 0.
    send_tick(8'h0D); send_tick(8'h0D); send_tick(8'h0D);
    check("row3_cursor", {bif.cur_row, bif.cur_col}, {2'd3, 5'd0});
    wlog.delete();
    for (int i = 0; i < 32; i++) send_tick(8'h30 + 8'(i));
    send_tick(8'h5A);
    check("wrap_nwrites", wlog.size(), 33);
    if (wlog.size() == 33) begin
      check("wrap_w31", wlog[31], {2'd3, 5'd31, 8'h4F});
      check("wrap_w32", wlog[32], {2'd0, 5'd0, 8'h5A});
    end
    check("wrap_cursor", {bif.cur_row, bif.cur_col}, {2'd0, 5'd1});

    // CRLF advances once; a lone LF advances.
    send_tick(8'h0D);
    for (int i = 0; i < 5; i++) send_tick(8'h61);
    check("at_1_5", {bif.cur_row, bif.cur_col}, {2'd1, 5'd5});
    wlog.delete();
    send_tick(8'h0D); send_tick(8'h0A);
    check("crlf_nwrites", wlog.size(), 0);
    check("crlf_cursor", {bif.cur_row, bif.cur_col}, {2'd2, 5'd0});
    send_tick(8'h0A);
    check("lf_cursor", {bif.cur_row, bif.cur_col}, {2'd3, 5'd0});

    // Backspace across a row boundary, then at home.
    send_tick(8'h0D); send_tick(8'h0D);
    wlog.delete();
    send_tick(8'h08);
    check("bs_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) check("bs_write", wlog[0], {2'd0, 5'd31, BLANK});
    check("bs_cursor", {bif.cur_row, bif.cur_col}, {2'd0, 5'd31});
    for (int i = 0; i < 4; i++) send_tick(8'h0D);
    wlog.delete();
    send_tick(8'h08);
    check("bs_home_nwrites", wlog.size(), 0);
    check("bs_home_cursor", {bif.cur_row, bif.cur_col}, 0);

    // Clear beats a simultaneous byte; a second request mid-sweep is ignored.
    send_tick(8'h4D);
    wlog.delete();
    busy_cnt = 0;
    bif.rx_valid = 1; bif.rx_data = 8'h51; bif.clr_req = 1;
    tick();
    bif.rx_valid = 0; bif.clr_req = 0;
    pulsed = 0;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (wlog.size() == 60 && !pulsed) begin bif.clr_req = 1; pulsed = 1; end
      else bif.clr_req = 0;
      if (!bif.busy) break;
    end
    bif.clr_req = 0;
    check("clear_done", bif.busy, 0);
    check("clear_nwrites", wlog.size(), NCELL);
    check("clear_busy_cycles", busy_cnt, NCELL);
    bad = 0;
    for (int i = 0; i < wlog.size() && i < NCELL; i++)
      if (wlog[i] != {7'(i), BLANK}) bad++;
    check("clear_order", bad, 0);
    check("clear_cursor", {bif.cur_row, bif.cur_col}, 0);
    check("clear_ready", bif.rx_ready, 1);
    tick(); tick();
    check("no_second_sweep", wlog.size(), NCELL);

    // Reset in the middle of a sweep.
    wlog.delete();
    bif.clr_req = 1; tick(); bif.clr_req = 0;
    for (int n = 0; n < 200 && wlog.size() < 40; n++) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_wr_en", bif.wr_en, 0);
    check("rst_mid_busy", bif.busy, 0);
    nlog = wlog.size();
    tick(); tick(); tick();
    check("rst_mid_nowrites", wlog.size(), nlog);
    rst_n = 1'b1;
    tick();
    check("rst_mid_ready", bif.rx_ready, 1);
    check("rst_mid_cursor", {bif.cur_row, bif.cur_col}, 0);
    check("rst_mid_idle", bif.busy, 0);

    // Random traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0: d = 8'h0D;
        1: d = 8'h0A;
        2, 3: d = 8'h08;
        4: d = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'(32'($urandom_range(0, 31)));
        default: d = 8'(32'($urandom_range(32'h20, 32'h7E)));
      endcase
      bif.rx_data  = d;
      bif.rx_valid = ($urandom_range(0, 2) != 0);
      bif.clr_req  = ($urandom_range(0, 299) == 0);
      tick();
    end
    bif.rx_valid = 0; bif.clr_req = 0;
    for (int n = 0; n < 200; n++) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
